data_bus_bridge: RTL

//  Stage-4 (Data Memory) bridge between the CPU data bus and a variable-latency data memory

---
 rtl/data_bus_bridge.sv | 116 +++++++++++
 1 files changed

// File: rtl/data_bus_bridge.sv
// data_bus_bridge: stage-4 bridge between the CPU data bus and a
// variable-latency data memory using a req/ack handshake.
//
// Ports:
//   i_clk, i_reset          clock, async active-high reset
//   i_valid, i_rw           CPU access request, 0=read 1=write
//   i_address, i_wdata      CPU byte address (word aligned), write data
//   o_rdata                 read data, valid in DONE
//   o_stall                 CPU holds stages 1-4 while high
//   o_error                 1-cycle pulse in DONE on misalign/timeout
//   o_mem_req, o_mem_we     memory request (held until ack), write enable
//   o_mem_addr, o_mem_wdata registered request address / write data
//   i_mem_ack, i_mem_rdata  memory completion pulse, read data
module data_bus_bridge #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic                  i_rw,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_stall,
    output logic                  o_error,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic                  i_mem_ack,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Width guarded so a disabled timeout still yields a legal vector.
    localparam int CW =
        (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0] CNT_LAST =
        TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          err_flag;
    logic          aligned;
    logic          timeout;

    assign aligned = (i_address[1:0] == 2'b00);
    assign timeout = TO_EN && (cnt == CNT_LAST);

    // Request and stall are decoded from state so that reset drops
    // them immediately rather than one edge later.
    assign o_mem_req = (state == S_REQ);
    assign o_stall   = (state == S_REQ) ||
                       ((state == S_IDLE) && i_valid);
    assign o_error   = (state == S_DONE) && err_flag;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            err_flag    <= 1'b0;
            o_rdata     <= '0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (i_valid) begin
                        if (aligned) begin
                            o_mem_addr  <= i_address;
                            o_mem_wdata <= i_wdata;
                            o_mem_we    <= i_rw;
                            err_flag    <= 1'b0;
                            state       <= S_REQ;
                        end else begin
                            // Misaligned: skip the memory entirely.
                            err_flag <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
                end
                S_REQ: begin
                    // Ack takes priority over a coincident timeout.
                    if (i_mem_ack) begin
                        if (!o_mem_we) o_rdata <= i_mem_rdata;
                        err_flag <= 1'b0;
                        state    <= S_DONE;
                    end else if (timeout) begin
                        if (!o_mem_we) o_rdata <= '0;
                        err_flag <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    // The request still on i_valid was already served.
                    cnt   <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
